// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I pipelined control unit: opcodes, ALU/immediate/result
// encodings and the control bundles carried through the stage registers.
package riscv_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  // ADD is encoded as zero so an all-zero bundle is a valid bubble.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic              reg_write;
    result_src_e       result_src;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              jalr;
    alu_ctrl_e         alu_ctrl;
    logic              alu_src;
    logic              alu_a_pc;
    logic [2:0]        funct3;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              use_rs1;
    logic              use_rs2;
  } ctrl_t;

  typedef struct packed {
    logic              reg_write;
    result_src_e       result_src;
    logic              mem_write;
    logic [REG_W-1:0]  rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    result_src_e       result_src;
    logic [REG_W-1:0]  rd;
  } wb_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE     = '0;
  localparam mem_ctrl_t MEM_CTRL_BUBBLE = '0;
  localparam wb_ctrl_t  WB_CTRL_BUBBLE  = '0;

  // funct7[5] means SUB only for register-register ops; it means SRA for both forms.
  function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3, input logic alt,
                                               input logic is_reg);
    case (funct3)
      3'd0:    return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_main_decode.sv
// Combinational RV32I main decoder: instruction word to control bundle, immediate
// format and illegal flag. Illegal encodings decode to a bubble.
module rv32i_main_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output imm_src_e    imm_src_o,
  output logic        illegal_o
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  assign funct7 = instr_i[31:25];
  assign funct3 = instr_i[14:12];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    ctrl_o      = CTRL_BUBBLE;
    imm_src_o   = IMM_I;
    illegal_o   = 1'b0;
    ctrl_o.rs1  = instr_i[19:15];
    ctrl_o.rs2  = instr_i[24:20];

    case (opcode_e'(instr_i[6:0]))
      OPC_OP: begin
        illegal_o        = !(funct7 == 7'h00 ||
                             (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct(funct3, funct7[5], 1'b1);
      end
      OPC_OP_IMM: begin
        illegal_o        = (funct3 == 3'd1 && funct7 != 7'h00) ||
                           (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct(funct3, funct7[5], 1'b0);
      end
      OPC_LOAD: begin
        illegal_o         = (funct3 == 3'd3) || (funct3 >= 3'd6);
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.use_rs1    = 1'b1;
        ctrl_o.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        illegal_o        = funct3 > 3'd2;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        imm_src_o        = IMM_S;
      end
      OPC_BRANCH: begin
        illegal_o       = (funct3 == 3'd2) || (funct3 == 3'd3);
        ctrl_o.branch   = 1'b1;
        ctrl_o.funct3   = funct3;
        ctrl_o.use_rs1  = 1'b1;
        ctrl_o.use_rs2  = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
        imm_src_o       = IMM_B;
      end
      OPC_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = ALU_PASS_B;
        imm_src_o        = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_a_pc  = 1'b1;
        imm_src_o        = IMM_U;
      end
      OPC_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_a_pc   = 1'b1;
        imm_src_o         = IMM_J;
      end
      OPC_JALR: begin
        illegal_o         = funct3 != 3'd0;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.use_rs1    = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase

    // rd travels only with writers, so stores and branches never match a hazard.
    if (ctrl_o.reg_write) ctrl_o.rd = instr_i[11:7];

    if (illegal_o) begin
      ctrl_o    = CTRL_BUBBLE;
      imm_src_o = IMM_I;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Five-stage RV32I control pipeline: decode in ID, control registers for ID/EX,
// EX/MEM and MEM/WB, load-use stall, branch flush and EX forwarding selects.
module pipelined_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  flush_id_o,
  output logic                  illegal_id_o,
  output logic [2:0]            imm_src_id_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_ex_o,
  output logic                  alu_src_ex_o,
  output logic                  alu_a_pc_ex_o,
  output logic                  branch_ex_o,
  output logic [2:0]            funct3_ex_o,
  output logic                  jump_ex_o,
  output logic                  jalr_ex_o,
  output logic [1:0]            fwd_a_ex_o,
  output logic [1:0]            fwd_b_ex_o,
  output logic                  mem_write_mem_o,
  output logic                  reg_write_wb_o,
  output logic [1:0]            result_src_wb_o,
  output logic [REG_ADDR_W-1:0] rd_wb_o
);

  ctrl_t     ctrl_id;
  imm_src_e  imm_src_id;
  logic      illegal_id;
  logic      load_use;

  ctrl_t     idex_d,  idex_q;
  mem_ctrl_t exmem_d, exmem_q;
  wb_ctrl_t  memwb_d, memwb_q;

  rv32i_main_decode u_decode (
    .instr_i   (instr_i),
    .ctrl_o    (ctrl_id),
    .imm_src_o (imm_src_id),
    .illegal_o (illegal_id)
  );

  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] rs,
                                         input mem_ctrl_t m, input wb_ctrl_t w);
    if (!used || rs == '0)              return FWD_RF;
    if (m.reg_write && m.rd == rs)      return FWD_MEM;
    if (w.reg_write && w.rd == rs)      return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    load_use = (idex_q.result_src == RES_MEM) && (idex_q.rd != '0) &&
               ((ctrl_id.use_rs1 && ctrl_id.rs1 == idex_q.rd) ||
                (ctrl_id.use_rs2 && ctrl_id.rs2 == idex_q.rd));

    idex_d = (branch_taken_i || load_use) ? CTRL_BUBBLE : ctrl_id;

    exmem_d            = MEM_CTRL_BUBBLE;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.result_src = idex_q.result_src;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.rd         = idex_q.rd;

    memwb_d            = WB_CTRL_BUBBLE;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.result_src = exmem_q.result_src;
    memwb_d.rd         = exmem_q.rd;
  end

  // NOTE: stage state uses non-blocking assignments so every stage samples the
  // previous-cycle value of the one before it; reset clears all stages at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q  <= CTRL_BUBBLE;
      exmem_q <= MEM_CTRL_BUBBLE;
      memwb_q <= WB_CTRL_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // A taken redirect squashes the ID instruction anyway, so it overrides the stall.
  assign stall_o      = load_use && !branch_taken_i;
  assign flush_id_o   = branch_taken_i;
  assign illegal_id_o = illegal_id;
  assign imm_src_id_o = imm_src_id;

  assign alu_ctrl_ex_o = ALU_CTRL_W'(idex_q.alu_ctrl);
  assign alu_src_ex_o  = idex_q.alu_src;
  assign alu_a_pc_ex_o = idex_q.alu_a_pc;
  assign branch_ex_o   = idex_q.branch;
  assign funct3_ex_o   = idex_q.funct3;
  assign jump_ex_o     = idex_q.jump;
  assign jalr_ex_o     = idex_q.jalr;
  assign fwd_a_ex_o    = fwd_sel(idex_q.use_rs1, idex_q.rs1, exmem_q, memwb_q);
  assign fwd_b_ex_o    = fwd_sel(idex_q.use_rs2, idex_q.rs2, exmem_q, memwb_q);

  assign mem_write_mem_o = exmem_q.mem_write;
  assign reg_write_wb_o  = memwb_q.reg_write;
  assign result_src_wb_o = memwb_q.result_src;
  assign rd_wb_o         = REG_ADDR_W'(memwb_q.rd);

endmodule
